// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, types and helpers
package mips_pkg;

  typedef logic [31:0] word_t;

  // PC_src redirect select encodings driven by the ID-stage controller
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  // sll $0,$0,0
  localparam word_t MIPS_NOP = 32'h0000_0000;

  // Opcode / funct values decoded by the controller
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    word_t instr;
    word_t pc_plus4;
    logic  valid;
  } if_id_t;

  // j/jal target: upper PC+4 nibble, 26-bit index, word aligned
  function automatic word_t jump_target(input word_t pc_plus4, input word_t instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory fetch bus between fetch stage and IM
interface fetch_unit_if;
  import mips_pkg::*;

  word_t IM_addr;
  word_t IM_rdata;
  logic  IM_ready;

  modport master (output IM_addr, input IM_rdata, input IM_ready);
  modport slave  (input IM_addr, output IM_rdata, output IM_ready);
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import mips_pkg::*;
#(
  parameter word_t NOP_WORD = MIPS_NOP
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load,
  input  logic   i_bubble,
  input  word_t  i_instr,
  input  word_t  i_pc_plus4,
  output if_id_t o_q
);

  if_id_t r_q;

  // Bubble wins over load; neither asserted means hold (stall)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};
    end else if (i_bubble) begin
      r_q <= '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};
    end else if (i_load) begin
      r_q <= '{instr: i_instr, pc_plus4: i_pc_plus4, valid: 1'b1};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS IF stage: PC, redirect priority, IF/ID register, redirect counter
module fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter word_t NOP_WORD = MIPS_NOP,
  parameter int    CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         PC_src,
  input  word_t              Branch_target,
  input  word_t              Jr_target,
  input  logic               Stall,
  fetch_unit_if.master       im,
  output word_t              ID_instruction,
  output word_t              ID_PC_plus4,
  output logic               ID_valid,
  output logic               ID_flush,
  output logic [CNT_W-1:0]   Redirect_count
);

  word_t            r_pc;
  logic [CNT_W-1:0] r_cnt;
  word_t            w_pc_plus4;
  word_t            w_jump_target;
  word_t            w_next_pc;
  logic             w_load;
  logic             w_bubble;
  logic             w_redirect;
  if_id_t           w_id;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_jump_target = jump_target(w_id.pc_plus4, w_id.instr);

  // Redirect priority: EX branch beats stall; stall masks ID jumps since a jr source may be the stalled load
  always_comb begin
    w_next_pc  = r_pc;
    w_load     = 1'b0;
    w_bubble   = 1'b0;
    w_redirect = 1'b0;
    if (PC_src == PCSRC_BR) begin
      w_next_pc  = Branch_target;
      w_bubble   = 1'b1;
      w_redirect = 1'b1;
    end else if (Stall) begin
      w_next_pc  = r_pc;
    end else if (PC_src == PCSRC_J) begin
      w_next_pc  = w_jump_target;
      w_bubble   = 1'b1;
      w_redirect = 1'b1;
    end else if (PC_src == PCSRC_JR) begin
      w_next_pc  = Jr_target;
      w_bubble   = 1'b1;
      w_redirect = 1'b1;
    end else if (!im.IM_ready) begin
      w_bubble   = 1'b1;
    end else begin
      w_next_pc  = w_pc_plus4;
      w_load     = 1'b1;
    end
  end

  // Program counter; a redirect during a busy fetch simply abandons it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Saturating count of taken redirects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_redirect && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_bubble  (w_bubble),
    .i_instr   (im.IM_rdata),
    .i_pc_plus4(w_pc_plus4),
    .o_q       (w_id)
  );

  assign im.IM_addr     = r_pc;
  assign ID_instruction = w_id.instr;
  assign ID_PC_plus4    = w_id.pc_plus4;
  assign ID_valid       = w_id.valid;
  assign ID_flush       = (PC_src == PCSRC_BR);
  assign Redirect_count = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed and random stimulus
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    word_t pc;
    word_t instr;
    word_t pc4;
    logic  valid;
    int    cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       pc_src = PCSRC_SEQ;
  word_t            branch_target = '0;
  word_t            jr_target = '0;
  logic             stall = 1'b0;
  word_t            id_instruction;
  word_t            id_pc_plus4;
  logic             id_valid;
  logic             id_flush;
  logic [CNT_W-1:0] redirect_count;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .NOP_WORD(MIPS_NOP), .CNT_W(CNT_W)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .PC_src        (pc_src),
    .Branch_target (branch_target),
    .Jr_target     (jr_target),
    .Stall         (stall),
    .im            (bus),
    .ID_instruction(id_instruction),
    .ID_PC_plus4   (id_pc_plus4),
    .ID_valid      (id_valid),
    .ID_flush      (id_flush),
    .Redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb_q[$];
  logic flush_q[$];
  word_t imem [word_t];

  word_t m_pc, m_instr, m_pc4;
  logic  m_valid;
  int    m_cnt;

  function automatic word_t im_read(input word_t a);
    if (imem.exists(a)) return imem[a];
    return a >> 2;
  endfunction

  task automatic check32(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_instr = MIPS_NOP;
    m_pc4   = '0;
    m_valid = 1'b0;
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic step(input logic [1:0] src, input logic stl, input logic rdy,
                      input word_t bt, input word_t jt);
    exp_t  e;
    word_t jtgt;
    pc_src        = src;
    stall         = stl;
    bus.IM_ready  = rdy;
    branch_target = bt;
    jr_target     = jt;
    bus.IM_rdata  = im_read(bus.IM_addr);
    flush_q.push_back(src == PCSRC_BR);
    jtgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
    if (src == PCSRC_BR) begin
      m_pc = bt;
      model_bubble();
    end else if (stl) begin
      m_pc = m_pc;
    end else if (src == PCSRC_J) begin
      m_pc = jtgt;
      model_bubble();
    end else if (src == PCSRC_JR) begin
      m_pc = jt;
      model_bubble();
    end else if (!rdy) begin
      m_instr = MIPS_NOP;
      m_pc4   = '0;
      m_valid = 1'b0;
    end else begin
      m_instr = im_read(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, cnt: m_cnt};
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    pc_src        = PCSRC_SEQ;
    stall         = 1'b0;
    bus.IM_ready  = 1'b1;
    branch_target = '0;
    jr_target     = '0;
    sb_q.delete();
    flush_q.delete();
    m_pc = '0; m_instr = MIPS_NOP; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0;
    @(posedge clk);
    #2;
    check32("rst_im_addr", bus.IM_addr, 32'h0);
    check32("rst_id_instr", id_instruction, MIPS_NOP);
    check32("rst_id_pc4", id_pc_plus4, 32'h0);
    check32("rst_id_valid", 32'(id_valid), 32'h0);
    check32("rst_cnt", 32'(redirect_count), 32'h0);
    reset = 1'b0;
  endtask

  // Monitor: registered outputs after each edge against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check32("im_addr", bus.IM_addr, e.pc);
        check32("id_instr", id_instruction, e.instr);
        check32("id_valid", 32'(id_valid), 32'(e.valid));
        if (e.valid) check32("id_pc4", id_pc_plus4, e.pc4);
        check32("redirect_cnt", 32'(redirect_count), 32'(e.cnt));
      end
    end
  end

  // Monitor: combinational flush mid-cycle while inputs are stable
  initial begin
    logic f;
    forever begin
      @(negedge clk);
      if (flush_q.size() > 0) begin
        f = flush_q.pop_front();
        check32("id_flush", 32'(id_flush), 32'(f));
      end
    end
  end

  initial begin
    int    r;
    logic [1:0] src;
    logic  stl, rdy;
    word_t bt, jt;
    bus.IM_ready = 1'b1;
    bus.IM_rdata = '0;

    // Reset and sequential fetch
    do_reset();
    repeat (3) step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);

    // j 0x40 -> target 0x100
    imem[32'h0000_000C] = 32'h0800_0040;
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);
    step(PCSRC_J,   1'b0, 1'b1, '0, '0);
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);

    // Branch beats stall
    step(PCSRC_BR, 1'b1, 1'b1, 32'h0000_0200, '0);
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);

    // Stall beats jr, then jr taken when stall drops
    step(PCSRC_JR, 1'b1, 1'b1, '0, 32'h0000_0300);
    step(PCSRC_JR, 1'b1, 1'b1, '0, 32'h0000_0300);
    step(PCSRC_JR, 1'b0, 1'b1, '0, 32'h0000_0300);

    // Memory busy for three cycles at 0x40
    step(PCSRC_BR, 1'b0, 1'b1, 32'h0000_0040, '0);
    repeat (3) step(PCSRC_SEQ, 1'b0, 1'b0, '0, '0);
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);

    // PC wrap
    step(PCSRC_BR, 1'b0, 1'b1, 32'hFFFF_FFFC, '0);
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);

    // Counter saturation with five jumps
    do_reset();
    repeat (5) step(PCSRC_J, 1'b0, 1'b1, '0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 0) do_reset();
      r   = $urandom_range(0, 9);
      src = (r < 6) ? PCSRC_SEQ : (r == 6) ? PCSRC_BR : (r == 7) ? PCSRC_J : PCSRC_JR;
      stl = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 4) != 0);
      bt  = $urandom() & 32'hFFFF_FFFC;
      jt  = $urandom() & 32'hFFFF_FFFC;
      step(src, stl, rdy, bt, jt);
    end

    // Asynchronous reset in the middle of a stalled cycle
    do_reset();
    step(PCSRC_BR, 1'b0, 1'b1, 32'h0000_0500, '0);
    step(PCSRC_SEQ, 1'b0, 1'b1, '0, '0);
    pc_src = PCSRC_SEQ;
    stall  = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check32("async_im_addr", bus.IM_addr, 32'h0);
    check32("async_id_instr", id_instruction, MIPS_NOP);
    check32("async_id_pc4", id_pc_plus4, 32'h0);
    check32("async_id_valid", 32'(id_valid), 32'h0);
    check32("async_cnt", 32'(redirect_count), 32'h0);
    check32("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Produces the ID-stage instruction word and PC+4 that the ID-stage controller decodes.
- Consumes the controller's 2-bit PC_src redirect select, the EX-stage branch target and the forwarded jr register value.
- Owns the PC, the instruction-memory fetch handshake, stall hold and flush/bubble insertion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, encoding inserted as a bubble (sll $0,$0,0).
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk  input  1  pipeline clock, all state on rising edge.
reset  input  1  asynchronous active-high reset.
PC_src  input  2  00 PC+4, 01 branch (EX), 10 j/jal (ID), 11 jr/jalr (ID).
Branch_target  input  32  taken-branch target from EX.
Jr_target  input  32  forwarded rs value for jr/jalr.
Stall  input  1  load-use stall from hazard unit; hold PC and IF/ID.
IM_addr  output  32  byte address to instruction memory; equals PC register.
IM_rdata  input  32  instruction word at IM_addr.
IM_ready  input  1  IM_rdata valid this cycle.
ID_instruction  output  32  IF/ID instruction register.
ID_PC_plus4  output  32  IF/ID PC+4 register.
ID_valid  output  1  1 = ID_instruction is a real fetched instruction, 0 = bubble.
ID_flush  output  1  combinational; 1 when PC_src==01, tells ID/EX to squash.
Redirect_count  output  CNT_W  saturating count of taken redirects.

Behaviour:
- Reset (async, any cycle, including mid-stall or mid-redirect):
  - PC=RESET_PC.
  - ID_instruction=NOP_WORD, ID_PC_plus4=0, ID_valid=0, Redirect_count=0.
  - First fetch at RESET_PC on the first edge after deassertion.
- Jump target: {ID_PC_plus4[31:28], ID_instruction[25:0], 2'b00}, computed internally.
- PC+4 arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Next-state priority, evaluated each edge (first match wins):
  1. PC_src==01 (EX branch):
     - PC<=Branch_target; IF/ID<=NOP_WORD, valid 0.
     - Overrides Stall and IM_ready.
  2. Stall==1:
     - PC and IF/ID hold.
     - PC_src 10/11 are ignored while stalled, because a jr rs may be the stalled load.
  3. PC_src==10:
     - PC<=jump target; IF/ID<=NOP_WORD, valid 0.
     - Exactly one bubble, as the fall-through fetch is squashed.
  4. PC_src==11:
     - PC<=Jr_target; IF/ID<=NOP_WORD, valid 0.
  5. IM_ready==0:
     - PC holds; IF/ID<=NOP_WORD, valid 0 (bubble while memory is busy).
  6. Normal:
     - IF/ID<=IM_rdata, ID_PC_plus4<=PC+4, valid 1; PC<=PC+4.
- A redirect taken while IM_ready==0 abandons the pending fetch; the new PC is issued next cycle.
- Redirect_count:
  - Increments on each edge where rule 1, 3 or 4 fires.
  - Saturates at all-ones; no wrap.
- Latency:
  - Fetched word appears on ID_instruction one edge after IM_addr presents its address with IM_ready=1.
  - Redirect-to-first-target-instruction in ID is 2 edges.
- ID_flush is purely combinational from PC_src; it does not depend on Stall.
- No internal state machine beyond the PC/IF-ID registers. PC_src is generated from ID_instruction, so in implementation it must not be sampled through a register.

Decomposition:
- Shared package (mips_pkg): PC_src encodings, as constants PCSRC_SEQ/PCSRC_BR/PCSRC_J/PCSRC_JR.
- mips_pkg also holds NOP_WORD and the opcode/funct constants used by the controller.
- One sub-module, if_id_reg: the IF/ID register with load/hold/bubble controls and async reset.
- fetch_unit keeps the PC, next-PC mux, priority logic and counter.

Test Plan:
- Reset sequence: release reset, IM_ready=1, IM returns addr>>2.
  - IM_addr must be 0, 4, 8.
  - ID_instruction must be 0, 1, 2 with ID_valid=1.
  - ID_PC_plus4 must be 4, 8, 12.
- Jump: ID holds j 0x0000040 (target 0x100) with PC_src=10.
  - Next cycle: IM_addr=0x100, ID_valid=0.
  - Following cycle: ID_PC_plus4=0x104.
  - Redirect_count=1.
- Branch beats stall: Stall=1 and PC_src=01 with Branch_target=0x200 in the same cycle.
  - Required: PC=0x200, ID bubble, ID_flush=1 during that cycle.
- Stall beats jr: Stall=1, PC_src=11, Jr_target=0x300.
  - Required: PC and ID hold.
  - Stall drops with PC_src=11: PC=0x300.
- IM_ready low 3 cycles at PC=0x40.
  - IM_addr stays 0x40; three ID_valid=0 bubbles.
  - Then the word at 0x40 enters ID.
- Wrap/saturation:
  - PC=0xFFFF_FFFC sequential fetch gives IM_addr=0 next.
  - CNT_W=2 with 5 jumps gives Redirect_count=3.
  - Reset asserted mid-stall clears all outputs immediately, without waiting for a clock edge.
